b_id_ex_stage: RTL

//  ID/EX pipeline register with operand forwarding and load-use hazard detection. It feeds the EX-stage ALU.
//  It latches the decoded ID fields and resolves RAW hazards from the EX/MEM and MEM/WB stages.
//  It inserts a one-cycle bubble on load-use and kills its contents on branch flush.
//  It delivers final ALU operands, shamt and ctrl, plus the forwarded store data.

---
 rtl/b_id_ex_stage_if.sv | 80 ++++++++
 rtl/b_id_ex_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/b_id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : b_id_ex_stage_if
// Description : Signal bundle between the decode stage, the downstream
//               pipeline stages and the ID/EX register. The "slave" modport
//               is the ID/EX stage; the "master" modport is whoever drives
//               the decoded instruction and the forwarding sources.
//   Signals (slave view):
//     in  b_id_*              decoded ID fields (valid, data, addrs, ctrl)
//     in  b_flush / b_hold    branch kill / downstream freeze
//     in  b_exmem_*, b_memwb_* forwarding sources
//     out b_stall             hold PC and IF/ID
//     out b_alu_*             final ALU operands, shamt, ctrl
//     out b_ex_*              store data, valid, rd, reg_write, mem_read
//     out b_bubble_cnt        saturating load-use bubble count
// Revision    : 1.0 - initial release
// ============================================================================
interface b_id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) ();
    logic              b_id_valid;
    logic [DATA_W-1:0] b_id_rs_data;
    logic [DATA_W-1:0] b_id_rt_data;
    logic [DATA_W-1:0] b_id_imm;
    logic [REG_AW-1:0] b_id_rs_addr;
    logic [REG_AW-1:0] b_id_rt_addr;
    logic [REG_AW-1:0] b_id_rd_addr;
    logic [4:0]        b_id_shamt;
    logic [3:0]        b_id_alu_ctrl;
    logic              b_id_alu_src;
    logic              b_id_reg_write;
    logic              b_id_mem_read;
    logic              b_flush;
    logic              b_hold;
    logic              b_exmem_reg_write;
    logic [REG_AW-1:0] b_exmem_rd_addr;
    logic [DATA_W-1:0] b_exmem_result;
    logic              b_memwb_reg_write;
    logic [REG_AW-1:0] b_memwb_rd_addr;
    logic [DATA_W-1:0] b_memwb_result;

    logic              b_stall;
    logic [DATA_W-1:0] b_alu_operand_1;
    logic [DATA_W-1:0] b_alu_operand_2;
    logic [4:0]        b_alu_shamt;
    logic [3:0]        b_alu_ctrl;
    logic [DATA_W-1:0] b_ex_store_data;
    logic              b_ex_valid;
    logic [REG_AW-1:0] b_ex_rd_addr;
    logic              b_ex_reg_write;
    logic              b_ex_mem_read;
    logic [CNT_W-1:0]  b_bubble_cnt;

    modport slave (
        input  b_id_valid, b_id_rs_data, b_id_rt_data, b_id_imm,
               b_id_rs_addr, b_id_rt_addr, b_id_rd_addr, b_id_shamt,
               b_id_alu_ctrl, b_id_alu_src, b_id_reg_write, b_id_mem_read,
               b_flush, b_hold,
               b_exmem_reg_write, b_exmem_rd_addr, b_exmem_result,
               b_memwb_reg_write, b_memwb_rd_addr, b_memwb_result,
        output b_stall, b_alu_operand_1, b_alu_operand_2, b_alu_shamt,
               b_alu_ctrl, b_ex_store_data, b_ex_valid, b_ex_rd_addr,
               b_ex_reg_write, b_ex_mem_read, b_bubble_cnt
    );

    modport master (
        output b_id_valid, b_id_rs_data, b_id_rt_data, b_id_imm,
               b_id_rs_addr, b_id_rt_addr, b_id_rd_addr, b_id_shamt,
               b_id_alu_ctrl, b_id_alu_src, b_id_reg_write, b_id_mem_read,
               b_flush, b_hold,
               b_exmem_reg_write, b_exmem_rd_addr, b_exmem_result,
               b_memwb_reg_write, b_memwb_rd_addr, b_memwb_result,
        input  b_stall, b_alu_operand_1, b_alu_operand_2, b_alu_shamt,
               b_alu_ctrl, b_ex_store_data, b_ex_valid, b_ex_rd_addr,
               b_ex_reg_write, b_ex_mem_read, b_bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/b_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : b_id_ex_stage
// Description : ID/EX pipeline register with operand forwarding from EX/MEM
//               and MEM/WB, load-use hazard detection (one-cycle bubble) and
//               branch-flush kill. Drives the combinational EX-stage ALU.
//   Ports:
//     i_clk  - clock, rising edge
//     i_rst  - synchronous active-high reset
//     bus    - b_id_ex_stage_if.slave (ID fields, flush/hold, forwarding
//              sources in; stall, ALU operands, EX controls, bubble count out)
// Revision    : 1.0 - initial release
// ============================================================================
module b_id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    b_id_ex_stage_if.slave       bus
);

    localparam logic [REG_AW-1:0] C_REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    logic              r_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic [4:0]        r_shamt;
    logic [3:0]        r_alu_ctrl;
    logic              r_alu_src;
    logic              r_reg_write;
    logic              r_mem_read;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_ex_reg_write;
    logic              w_ex_mem_read;
    logic              w_load_use;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Younger producer (EX/MEM) wins over MEM/WB; r0 is hard-wired and
    // never takes a forwarded value.
    function automatic logic [DATA_W-1:0] f_forward(
        input logic [REG_AW-1:0] src_addr,
        input logic [DATA_W-1:0] reg_data,
        input logic              exmem_wr,
        input logic [REG_AW-1:0] exmem_rd,
        input logic [DATA_W-1:0] exmem_res,
        input logic              memwb_wr,
        input logic [REG_AW-1:0] memwb_rd,
        input logic [DATA_W-1:0] memwb_res
    );
        logic [DATA_W-1:0] v;
        v = reg_data;
        if (src_addr != C_REG_ZERO) begin
            if (exmem_wr && (exmem_rd == src_addr)) begin
                v = exmem_res;
            end else if (memwb_wr && (memwb_rd == src_addr)) begin
                v = memwb_res;
            end
        end
        return v;
    endfunction

    assign w_ex_reg_write = r_valid & r_reg_write;
    assign w_ex_mem_read  = r_valid & r_mem_read;

    // Both source fields are compared even when the ID instruction does not
    // actually read rt; a spurious bubble is cheaper than decoding usage here.
    assign w_load_use = w_ex_mem_read
                      & (r_rd_addr != C_REG_ZERO)
                      & bus.b_id_valid
                      & ((r_rd_addr == bus.b_id_rs_addr) |
                         (r_rd_addr == bus.b_id_rt_addr));

    assign w_fwd_rs = f_forward(r_rs_addr, r_rs_data,
                                bus.b_exmem_reg_write, bus.b_exmem_rd_addr,
                                bus.b_exmem_result,
                                bus.b_memwb_reg_write, bus.b_memwb_rd_addr,
                                bus.b_memwb_result);

    assign w_fwd_rt = f_forward(r_rt_addr, r_rt_data,
                                bus.b_exmem_reg_write, bus.b_exmem_rd_addr,
                                bus.b_exmem_result,
                                bus.b_memwb_reg_write, bus.b_memwb_rd_addr,
                                bus.b_memwb_result);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_rd_addr    <= '0;
            r_shamt      <= '0;
            r_alu_ctrl   <= '0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (bus.b_hold) begin
            // Freeze: all registers keep their value. A pending flush is
            // held by its source until hold drops, so nothing is lost.
        end else if (bus.b_flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (w_load_use) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            if (r_bubble_cnt != C_CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
            end
        end else begin
            r_valid     <= bus.b_id_valid;
            r_rs_data   <= bus.b_id_rs_data;
            r_rt_data   <= bus.b_id_rt_data;
            r_imm       <= bus.b_id_imm;
            r_rs_addr   <= bus.b_id_rs_addr;
            r_rt_addr   <= bus.b_id_rt_addr;
            r_rd_addr   <= bus.b_id_rd_addr;
            r_shamt     <= bus.b_id_shamt;
            r_alu_ctrl  <= bus.b_id_alu_ctrl;
            r_alu_src   <= bus.b_id_alu_src;
            r_reg_write <= bus.b_id_reg_write;
            r_mem_read  <= bus.b_id_mem_read;
        end
    end

    // A flush kills the consumer anyway, so it suppresses the load-use stall.
    assign bus.b_stall         = bus.b_hold | (w_load_use & ~bus.b_flush);
    assign bus.b_alu_operand_1 = w_fwd_rs;
    assign bus.b_alu_operand_2 = r_alu_src ? r_imm : w_fwd_rt;
    assign bus.b_alu_shamt     = r_shamt;
    assign bus.b_alu_ctrl      = r_alu_ctrl;
    assign bus.b_ex_store_data = w_fwd_rt;
    assign bus.b_ex_valid      = r_valid;
    assign bus.b_ex_rd_addr    = r_rd_addr;
    assign bus.b_ex_reg_write  = w_ex_reg_write;
    assign bus.b_ex_mem_read   = w_ex_mem_read;
    assign bus.b_bubble_cnt    = r_bubble_cnt;

endmodule
`default_nettype wire
